regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
- Writeback-side companion of the 32x64 register file.
- Accepts results from the execute and memory units over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle into the register file write port (RegWrite/WriteRegister/WriteData).
- Provides two forwarding lookups so read ports see pending, not-yet-committed values.

Parameters:
DEPTH, 4, number of buffered writeback entries (power of two, >=2)
DATA_W, 64, data width, matches register file
ADDR_W, 5, register index width

Ports:
clk  input  1  rising-edge clock, same clock as register file
reset  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a result
in_ready  output  1  queue can accept (not full)
in_reg  input  ADDR_W  destination register index
in_data  input  DATA_W  result value
wb_enable  input  1  write port available this cycle; low holds the queue
RegWrite  output  1  write strobe to register file
WriteRegister  output  ADDR_W  write index to register file
WriteData  output  DATA_W  write data to register file
fwd_reg1  input  ADDR_W  read port 1 index (same as ReadRegister1)
fwd_hit1  output  1  a pending entry targets fwd_reg1
fwd_data1  output  DATA_W  youngest pending value for fwd_reg1, 0 if no hit
fwd_reg2  input  ADDR_W  read port 2 index
fwd_hit2  output  1  as fwd_hit1 for port 2
fwd_data2  output  DATA_W  as fwd_data1 for port 2
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer with head/tail pointers wrapping modulo DEPTH, plus occupancy counter, all registered.
- Reset (reset=0, async): head=tail=0, count=0, all entry valid bits cleared. Pending entries are discarded with no write issued. Outputs while in reset: in_ready=1, RegWrite=0, WriteRegister=31, WriteData=0, fwd_hit*=0, fwd_data*=0, count=0.
- in_ready = (count < DEPTH). It is combinational from registered count and does not depend on the same-cycle pop, so a full queue never accepts, even while draining.
- Push: when in_valid & in_ready, the entry is written at tail on the clock edge and tail advances.
- Push to register 31: the handshake completes (in_ready honoured), but the entry is dropped. Tail and count are unchanged. X31 is hardwired zero.
- Drain outputs are combinational from head:
  - RegWrite = wb_enable & (count != 0).
  - WriteRegister = head index and WriteData = head data when count != 0.
  - Otherwise WriteRegister=31 and WriteData=0.
- Pop: on an edge where RegWrite=1, head advances. The register file captures the value on the same edge. Write latency from push to RegWrite is at least 1 cycle; a pushed value never reaches the write port in its push cycle.
- Simultaneous push and pop: both occur and count is unchanged. When count=0, the pushed entry appears at the write port the next cycle.
- Count update: count += push_kept - pop. It never exceeds DEPTH and never underflows.
- Ordering: strictly in-order. Two writes to the same register commit oldest first.
- Forwarding, per port, fully combinational:
  - Scan all valid entries, including the head being written this cycle.
  - fwd_hit = 1 if any entry index equals fwd_reg. fwd_data = data of the youngest (closest to tail) matching entry.
  - fwd_reg=31 never hits.
  - The in-flight in_data of the current cycle is not forwarded.
- wb_enable low: no pop and RegWrite=0. Pushes continue until full. Forwarding remains active.

Test Plan:
- Reset, then push (r3, 0xAAAA) with wb_enable=1: in_ready=1; next cycle RegWrite=1, WriteRegister=3, WriteData=0xAAAA, count=1; following cycle count=0, RegWrite=0, WriteRegister=31.
- wb_enable=0, push r1..r4 with data 0x11..0x44: count=4 and in_ready=0. A 5th push (r5) with in_valid=1 is not accepted. Raise wb_enable: writes commit r1, r2, r3, r4 on consecutive cycles, then r5 is accepted once in_ready=1.
- Push (r7, 0x1) then (r7, 0x2) with wb_enable=0; fwd_reg1=7: fwd_hit1=1, fwd_data1=0x2. With fwd_reg2=8: fwd_hit2=0, fwd_data2=0.
- Push (r31, 0xDEAD): handshake completes, count stays 0, RegWrite never asserts, and fwd_reg1=31 gives fwd_hit1=0.
- Full queue with wb_enable=1 and in_valid=1 held: in_ready=0 every full cycle, no entry lost or duplicated. The commit sequence equals the push sequence (scoreboard check).
- With 3 entries pending, assert reset=0 mid-cycle (asynchronously): count=0 and RegWrite=0 immediately. After release, no stale writes appear and the forwarding lookups miss.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// In-order writeback buffer in front of the register file write port, with two
// combinational forwarding lookups over the pending entries.
module regfile_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_reg,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     wb_enable,
   output logic                     RegWrite,
   output logic [ADDR_W-1:0]        WriteRegister,
   output logic [DATA_W-1:0]        WriteData,
   input  logic [ADDR_W-1:0]        fwd_reg1,
   output logic                     fwd_hit1,
   output logic [DATA_W-1:0]        fwd_data1,
   input  logic [ADDR_W-1:0]        fwd_reg2,
   output logic                     fwd_hit2,
   output logic [DATA_W-1:0]        fwd_data2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_REG = '1;

   logic [ADDR_W-1:0] reg_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_acc, push_kept, nonempty;
   logic [PTR_W-1:0]  idx;

   always_comb begin
      in_ready      = (count_q < FULL);
      push_acc      = in_valid & in_ready;
      // X31 is hardwired zero: handshake completes but nothing is stored
      push_kept     = push_acc & (in_reg != ZERO_REG);
      nonempty      = (count_q != '0);
      RegWrite      = wb_enable & nonempty;
      WriteRegister = nonempty ? reg_q[head_q]  : ZERO_REG;
      WriteData     = nonempty ? data_q[head_q] : '0;
      head_d        = head_q + PTR_W'(RegWrite);
      tail_d        = tail_q + PTR_W'(push_kept);
      count_d       = count_q + CNT_W'(push_kept) - CNT_W'(RegWrite);
   end

   assign count = count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (RegWrite)  vld_q[head_q] <= 1'b0;
         if (push_kept) vld_q[tail_q] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_kept) begin
         reg_q[tail_q]  <= in_reg;
         data_q[tail_q] <= in_data;
      end
   end

   // Scan oldest to youngest so the last match (closest to tail) wins
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (vld_q[idx] && (reg_q[idx] == fwd_reg1) && (fwd_reg1 != ZERO_REG)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = data_q[idx];
         end
         if (vld_q[idx] && (reg_q[idx] == fwd_reg2) && (fwd_reg2 != ZERO_REG)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = data_q[idx];
         end
      end
   end

endmodule
